// File: rtl/dma_axi64_slave_mem.sv
// dma_axi64_slave_mem
//   AXI3-style 64-bit slave memory used to terminate the DMA controller's
//   channel-0 master port in benches. INCR bursts only, one outstanding
//   write and one outstanding read, handled by independent engines.
//
// Ports
//   clk, reset          : clock, asynchronous active-low reset
//   AW*0 / W*0 / B*0    : write address, data, response channels
//   AR*0 / R*0          : read address and data channels
//   proto_err           : sticky flag for master-side protocol violations
//                         (valid dropped before ready, WLAST misplacement)
//
// Optional feature
//   AXI_SLV_RANGE_ERR_EN : when defined, out-of-range beats are not written,
//                          reads return zero, and the response is SLVERR.
//                          When undefined, addresses wrap modulo MEM_DEPTH.
module dma_axi64_slave_mem #(
   parameter int          ID_BITS   = 4,
   parameter int          LEN_BITS  = 4,
   parameter int          SIZE_BITS = 2,
   parameter int          MEM_DEPTH = 1024,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          RDY_LAT   = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [ID_BITS-1:0]   AWID0,
   input  logic [31:0]          AWADDR0,
   input  logic [LEN_BITS-1:0]  AWLEN0,
   input  logic [SIZE_BITS-1:0] AWSIZE0,
   input  logic                 AWVALID0,
   output logic                 AWREADY0,
   input  logic [ID_BITS-1:0]   WID0,
   input  logic [63:0]          WDATA0,
   input  logic [7:0]           WSTRB0,
   input  logic                 WLAST0,
   input  logic                 WVALID0,
   output logic                 WREADY0,
   output logic [ID_BITS-1:0]   BID0,
   output logic [1:0]           BRESP0,
   output logic                 BVALID0,
   input  logic                 BREADY0,
   input  logic [ID_BITS-1:0]   ARID0,
   input  logic [31:0]          ARADDR0,
   input  logic [LEN_BITS-1:0]  ARLEN0,
   input  logic [SIZE_BITS-1:0] ARSIZE0,
   input  logic                 ARVALID0,
   output logic                 ARREADY0,
   output logic [ID_BITS-1:0]   RID0,
   output logic [63:0]          RDATA0,
   output logic [1:0]           RRESP0,
   output logic                 RLAST0,
   output logic                 RVALID0,
   input  logic                 RREADY0,
   output logic                 proto_err
);

   localparam int          IDX_W     = $clog2(MEM_DEPTH);
   localparam logic [31:0] MEM_BYTES = 32'(MEM_DEPTH) << 3;
   localparam logic [2:0]  LAT       = 3'(RDY_LAT);

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
   typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

   logic [63:0] mem [MEM_DEPTH];

   // WID is not used by an AXI3 slave that does not interleave.
   logic unused_wid;
   assign unused_wid = ^WID0;

   function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
      return IDX_W'((a - BASE_ADDR) >> 3);
   endfunction

   function automatic logic in_range(input logic [31:0] a);
      return (a - BASE_ADDR) < MEM_BYTES;
   endfunction

   // Following beat: align current address down to the beat size, then step.
   function automatic logic [31:0] next_addr(input logic [31:0] a,
                                             input logic [SIZE_BITS-1:0] s);
      logic [31:0] nb;
      nb = 32'd1 << s;
      return (a & ~(nb - 32'd1)) + nb;
   endfunction

   // ---------------------------------------------------------------- write
   w_state_t              w_state, w_next;
   logic [2:0]            aw_cnt;
   logic                  aw_pend, w_perr, w_err;
   logic [ID_BITS-1:0]    w_id;
   logic [31:0]           w_addr;
   logic [LEN_BITS-1:0]   w_len, w_beat;
   logic [SIZE_BITS-1:0]  w_size;
   logic                  aw_hs, w_hs, wr_ok;

   always_comb begin
      w_next   = w_state;
      AWREADY0 = 1'b0;
      WREADY0  = 1'b0;
      aw_hs    = 1'b0;
      w_hs     = 1'b0;
      case (w_state)
         W_IDLE: begin
            // reset gate keeps ready low in reset even when RDY_LAT is 0
            if (AWVALID0 && aw_cnt == LAT && reset) begin
               AWREADY0 = 1'b1;
               aw_hs    = 1'b1;
               w_next   = W_DATA;
            end
         end
         W_DATA: begin
            WREADY0 = 1'b1;
            if (WVALID0) begin
               w_hs = 1'b1;
               if (w_beat == w_len) w_next = W_RESP;
            end
         end
         W_RESP: if (BREADY0) w_next = W_IDLE;
         default: w_next = W_IDLE;
      endcase
   end

`ifdef AXI_SLV_RANGE_ERR_EN
   assign wr_ok = in_range(w_addr);
`else
   assign wr_ok = 1'b1;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         w_state <= W_IDLE;
         aw_cnt  <= '0;
         aw_pend <= 1'b0;
         w_perr  <= 1'b0;
         w_err   <= 1'b0;
         w_id    <= '0;
         w_addr  <= '0;
         w_len   <= '0;
         w_size  <= '0;
         w_beat  <= '0;
      end else begin
         w_state <= w_next;
         aw_cnt  <= (w_state == W_IDLE && AWVALID0 && !aw_hs) ? aw_cnt + 3'd1 : 3'd0;
         // aw_pend: AWVALID was up in IDLE last cycle without a handshake,
         // so it must still be up now.
         aw_pend <= (w_state == W_IDLE) && AWVALID0 && !aw_hs;
         if (aw_pend && !AWVALID0) w_perr <= 1'b1;
         if (aw_hs) begin
            w_id   <= AWID0;
            w_addr <= AWADDR0;
            w_len  <= AWLEN0;
            w_size <= AWSIZE0;
            w_beat <= '0;
            w_err  <= 1'b0;
         end else if (w_hs) begin
            w_addr <= next_addr(w_addr, w_size);
            w_beat <= w_beat + LEN_BITS'(1);
            if (WLAST0 != (w_beat == w_len)) w_perr <= 1'b1;
            if (!wr_ok) w_err <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_hs && wr_ok) begin
         for (int b = 0; b < 8; b++)
            if (WSTRB0[b]) mem[word_idx(w_addr)][b*8 +: 8] <= WDATA0[b*8 +: 8];
      end
   end

   assign BVALID0 = (w_state == W_RESP);
   assign BID0    = w_id;
   assign BRESP0  = {w_err, 1'b0};

   // ----------------------------------------------------------------- read
   r_state_t              r_state, r_next;
   logic [2:0]            ar_cnt;
   logic                  ar_pend, r_perr;
   logic [ID_BITS-1:0]    r_id;
   logic [31:0]           r_addr, rd_addr;
   logic [LEN_BITS-1:0]   r_len, r_beat;
   logic [SIZE_BITS-1:0]  r_size;
   logic [63:0]           rdata, rd_word;
   logic [1:0]            rresp;
   logic                  ar_hs, r_hs, rd_ok;

   always_comb begin
      r_next   = r_state;
      ARREADY0 = 1'b0;
      ar_hs    = 1'b0;
      r_hs     = 1'b0;
      case (r_state)
         R_IDLE: begin
            if (ARVALID0 && ar_cnt == LAT && reset) begin
               ARREADY0 = 1'b1;
               ar_hs    = 1'b1;
               r_next   = R_DATA;
            end
         end
         R_DATA: begin
            if (RREADY0) begin
               r_hs = 1'b1;
               if (r_beat == r_len) r_next = R_IDLE;
            end
         end
         default: r_next = R_IDLE;
      endcase
   end

   // Beat data is registered when the beat is loaded (AR handshake or the
   // previous R handshake), which keeps RDATA stable across stalls and gives
   // old-data semantics against a write to the same word on that edge.
   always_comb begin
      rd_addr = ar_hs ? ARADDR0 : next_addr(r_addr, r_size);
      rd_word = mem[word_idx(rd_addr)];
`ifdef AXI_SLV_RANGE_ERR_EN
      rd_ok   = in_range(rd_addr);
`else
      rd_ok   = 1'b1;
`endif
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= R_IDLE;
         ar_cnt  <= '0;
         ar_pend <= 1'b0;
         r_perr  <= 1'b0;
         r_id    <= '0;
         r_addr  <= '0;
         r_len   <= '0;
         r_size  <= '0;
         r_beat  <= '0;
         rdata   <= '0;
         rresp   <= '0;
      end else begin
         r_state <= r_next;
         ar_cnt  <= (r_state == R_IDLE && ARVALID0 && !ar_hs) ? ar_cnt + 3'd1 : 3'd0;
         ar_pend <= (r_state == R_IDLE) && ARVALID0 && !ar_hs;
         if (ar_pend && !ARVALID0) r_perr <= 1'b1;
         if (ar_hs) begin
            r_id   <= ARID0;
            r_addr <= ARADDR0;
            r_len  <= ARLEN0;
            r_size <= ARSIZE0;
            r_beat <= '0;
         end else if (r_hs && r_beat != r_len) begin
            r_addr <= rd_addr;
            r_beat <= r_beat + LEN_BITS'(1);
         end
         if (ar_hs || (r_hs && r_beat != r_len)) begin
            rdata <= rd_ok ? rd_word : 64'd0;
            rresp <= rd_ok ? 2'b00 : 2'b10;
         end
      end
   end

   assign RVALID0   = (r_state == R_DATA);
   assign RLAST0    = (r_state == R_DATA) && (r_beat == r_len);
   assign RID0      = r_id;
   assign RDATA0    = rdata;
   assign RRESP0    = rresp;
   assign proto_err = w_perr | r_perr;

endmodule

// File: tb/tb_dma_axi64_slave_mem.sv
// Self-checking bench for dma_axi64_slave_mem: directed cases from the test
// plan plus randomized write/read-back bursts against a byte-level model.
module tb_dma_axi64_slave_mem;
   localparam int          ID_BITS   = 4;
   localparam int          LEN_BITS  = 4;
   localparam int          SIZE_BITS = 2;
   localparam int          MEM_DEPTH = 1024;
   localparam logic [31:0] BASE_ADDR = 32'h0000_0000;
   localparam int          RDY_LAT   = 3;
`ifdef AXI_SLV_RANGE_ERR_EN
   localparam bit RANGE_EN = 1'b1;
`else
   localparam bit RANGE_EN = 1'b0;
`endif

   logic                 clk = 0, reset;
   logic [ID_BITS-1:0]   AWID0, WID0, BID0, ARID0, RID0;
   logic [31:0]          AWADDR0, ARADDR0;
   logic [LEN_BITS-1:0]  AWLEN0, ARLEN0;
   logic [SIZE_BITS-1:0] AWSIZE0, ARSIZE0;
   logic                 AWVALID0, AWREADY0, WLAST0, WVALID0, WREADY0;
   logic [63:0]          WDATA0, RDATA0;
   logic [7:0]           WSTRB0;
   logic [1:0]           BRESP0, RRESP0;
   logic                 BVALID0, BREADY0, ARVALID0, ARREADY0;
   logic                 RLAST0, RVALID0, RREADY0, proto_err;

   dma_axi64_slave_mem #(.ID_BITS(ID_BITS), .LEN_BITS(LEN_BITS), .SIZE_BITS(SIZE_BITS),
      .MEM_DEPTH(MEM_DEPTH), .BASE_ADDR(BASE_ADDR), .RDY_LAT(RDY_LAT)) dut (
      .clk(clk), .reset(reset),
      .AWID0(AWID0), .AWADDR0(AWADDR0), .AWLEN0(AWLEN0), .AWSIZE0(AWSIZE0),
      .AWVALID0(AWVALID0), .AWREADY0(AWREADY0),
      .WID0(WID0), .WDATA0(WDATA0), .WSTRB0(WSTRB0), .WLAST0(WLAST0),
      .WVALID0(WVALID0), .WREADY0(WREADY0),
      .BID0(BID0), .BRESP0(BRESP0), .BVALID0(BVALID0), .BREADY0(BREADY0),
      .ARID0(ARID0), .ARADDR0(ARADDR0), .ARLEN0(ARLEN0), .ARSIZE0(ARSIZE0),
      .ARVALID0(ARVALID0), .ARREADY0(ARREADY0),
      .RID0(RID0), .RDATA0(RDATA0), .RRESP0(RRESP0), .RLAST0(RLAST0),
      .RVALID0(RVALID0), .RREADY0(RREADY0), .proto_err(proto_err));

   always #5 clk = ~clk;

   typedef struct { logic [ID_BITS-1:0] id; logic [1:0] resp; } b_exp_t;
   typedef struct {
      logic [63:0] data; logic [63:0] mask; logic [ID_BITS-1:0] id;
      logic [1:0] resp; logic last;
   } r_exp_t;

   b_exp_t      bq[$];
   r_exp_t      rq[$];
   logic [7:0]  mb [MEM_DEPTH*8];   // model memory, one entry per byte
   bit          kn [MEM_DEPTH*8];   // byte has been written at least once
   logic [63:0] wbuf_d [16];
   logic [7:0]  wbuf_s [16];
   int          n_cmp = 0, n_fail = 0, nb_done = 0, nr_done = 0;
   logic [63:0] last_rdata;
   logic [1:0]  last_bresp, last_rresp;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------ model
   function automatic logic [31:0] beat_addr(input logic [31:0] a, input int sz, input int i);
      logic [31:0] nb;
      nb = 32'd1 << sz;
      if (i == 0) return a;
      return (a & ~(nb - 32'd1)) + nb * 32'(i);
   endfunction

   function automatic int widx(input logic [31:0] a);
      return int'(((a - BASE_ADDR) >> 3) % 32'(MEM_DEPTH));
   endfunction

   function automatic bit in_rng(input logic [31:0] a);
      return (a - BASE_ADDR) < 32'(MEM_DEPTH * 8);
   endfunction

   function automatic void mdl_word(input logic [31:0] a, output logic [63:0] d,
                                    output logic [63:0] m);
      int w;
      w = widx(a);
      d = '0; m = '0;
      for (int b = 0; b < 8; b++) begin
         d[b*8 +: 8] = mb[w*8+b];
         m[b*8 +: 8] = kn[w*8+b] ? 8'hFF : 8'h00;
      end
   endfunction

   // --------------------------------------------------------- monitor
   always @(negedge clk) begin
      if (reset) begin
         if (BVALID0) begin
            chk("b_expected", 64'(bq.size() != 0), 1);
            if (bq.size() != 0) begin
               chk("bid", BID0, bq[0].id);
               chk("bresp", BRESP0, bq[0].resp);
               last_bresp = BRESP0;
               if (BREADY0) begin void'(bq.pop_front()); nb_done++; end
            end
         end
         if (RVALID0) begin
            chk("r_expected", 64'(rq.size() != 0), 1);
            if (rq.size() != 0) begin
               chk("rdata", RDATA0 & rq[0].mask, rq[0].data & rq[0].mask);
               chk("rid", RID0, rq[0].id);
               chk("rresp", RRESP0, rq[0].resp);
               chk("rlast", RLAST0, rq[0].last);
               if (RREADY0) begin
                  last_rdata = RDATA0; last_rresp = RRESP0;
                  void'(rq.pop_front()); nr_done++;
               end
            end
         end
      end
   end

   // ---------------------------------------------------------- drivers
   task automatic do_write(input logic [ID_BITS-1:0] id, input logic [31:0] addr,
                           input int len, input int sz, input bit bad_last, input bit gaps);
      b_exp_t      be;
      bit          oor, got;
      int          wc, start, w;
      logic [31:0] a;
      oor = 0;
      for (int i = 0; i <= len; i++) if (!in_rng(beat_addr(addr, sz, i))) oor = 1;
      be.id = id; be.resp = (RANGE_EN && oor) ? 2'b10 : 2'b00;
      bq.push_back(be);
      AWID0 = id; AWADDR0 = addr; AWLEN0 = LEN_BITS'(len); AWSIZE0 = SIZE_BITS'(sz);
      AWVALID0 = 1;
      got = 0; wc = 0;
      for (int c = 0; c < 20 && !got; c++) begin
         @(negedge clk);
         if (AWREADY0) got = 1; else wc++;
      end
      @(posedge clk); #1;
      AWVALID0 = 0;
      chk("aw_latency", got ? wc : 99, RDY_LAT);
      for (int i = 0; i <= len; i++) begin
         if (gaps) repeat ($urandom_range(0, 2)) begin WVALID0 = 0; @(posedge clk); #1; end
         WVALID0 = 1; WID0 = id; WDATA0 = wbuf_d[i]; WSTRB0 = wbuf_s[i];
         WLAST0 = ((i == len) != bad_last);
         got = 0;
         for (int c = 0; c < 20 && !got; c++) begin @(negedge clk); got = WREADY0; end
         @(posedge clk); #1;
         chk("w_ready", got, 1);
         a = beat_addr(addr, sz, i);
         w = widx(a);
         if (got && !(RANGE_EN && !in_rng(a)))
            for (int b = 0; b < 8; b++)
               if (wbuf_s[i][b]) begin mb[w*8+b] = wbuf_d[i][b*8 +: 8]; kn[w*8+b] = 1; end
      end
      WVALID0 = 0; WLAST0 = 0;
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      start = nb_done;
      BREADY0 = 1;
      for (int c = 0; c < 30 && nb_done == start; c++) @(posedge clk);
      #1 BREADY0 = 0;
      chk("b_done", nb_done - start, 1);
   endtask

   task automatic start_read(input logic [ID_BITS-1:0] id, input logic [31:0] addr,
                             input int len, input int sz);
      r_exp_t      re;
      logic [31:0] a;
      bit          got;
      int          wc;
      for (int i = 0; i <= len; i++) begin
         a = beat_addr(addr, sz, i);
         mdl_word(a, re.data, re.mask);
         re.resp = 2'b00;
         if (RANGE_EN && !in_rng(a)) begin re.data = '0; re.mask = '1; re.resp = 2'b10; end
         re.id = id; re.last = (i == len);
         rq.push_back(re);
      end
      ARID0 = id; ARADDR0 = addr; ARLEN0 = LEN_BITS'(len); ARSIZE0 = SIZE_BITS'(sz);
      ARVALID0 = 1;
      got = 0; wc = 0;
      for (int c = 0; c < 20 && !got; c++) begin
         @(negedge clk);
         if (ARREADY0) got = 1; else wc++;
      end
      @(posedge clk); #1;
      ARVALID0 = 0;
      chk("ar_latency", got ? wc : 99, RDY_LAT);
   endtask

   task automatic do_read(input logic [ID_BITS-1:0] id, input logic [31:0] addr,
                          input int len, input int sz, input bit use_pat);
      int         target, k;
      logic [3:0] pat;
      pat = 4'b1001;
      target = nr_done + len + 1;
      start_read(id, addr, len, sz);
      k = 0;
      for (int c = 0; c < 300 && nr_done < target; c++) begin
         RREADY0 = use_pat ? pat[3 - (k % 4)] : ($urandom_range(0, 2) != 0);
         k++;
         @(posedge clk); #1;
      end
      RREADY0 = 0;
      chk("r_done", nr_done, target);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ------------------------------------------------------------- main
   initial begin
      logic [31:0] a;
      int          l, s;
      reset = 0;
      AWID0 = 0; AWADDR0 = 0; AWLEN0 = 0; AWSIZE0 = 0; AWVALID0 = 0;
      WID0 = 0; WDATA0 = 0; WSTRB0 = 0; WLAST0 = 0; WVALID0 = 0; BREADY0 = 0;
      ARID0 = 0; ARADDR0 = 0; ARLEN0 = 0; ARSIZE0 = 0; ARVALID0 = 0; RREADY0 = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_awready", AWREADY0, 0);
      chk("rst_wready",  WREADY0, 0);
      chk("rst_bvalid",  BVALID0, 0);
      chk("rst_arready", ARREADY0, 0);
      chk("rst_rvalid",  RVALID0, 0);
      chk("rst_rlast",   RLAST0, 0);
      chk("rst_rdata",   RDATA0, 0);
      chk("rst_bid",     BID0, 0);
      chk("rst_proto",   proto_err, 0);
      @(posedge clk); #1 reset = 1;
      repeat (2) begin @(posedge clk); #1; end

      // single write then read
      wbuf_d[0] = 64'h1122334455667788; wbuf_s[0] = 8'hFF;
      do_write(4'h5, 32'h40, 0, 3, 0, 0);
      begin
         logic [63:0] d, m;
         mdl_word(32'h40, d, m);
         chk("mdl_word40", d, 64'h1122334455667788);
      end
      do_read(4'h9, 32'h40, 0, 3, 0);
      chk("t1_rdata", last_rdata, 64'h1122334455667788);
      chk("t1_rresp", last_rresp, 0);

      // burst with R backpressure 1-0-0-1
      for (int i = 0; i < 4; i++) begin
         wbuf_d[i] = {32'hA0A0_0000 + 32'(i), 32'h0B0B_0000 + 32'(i)}; wbuf_s[i] = 8'hFF;
      end
      do_write(4'h3, 32'h100, 3, 3, 0, 1);
      do_read(4'h4, 32'h100, 3, 3, 1);
      chk("t2_last_beat", last_rdata, 64'hA0A0_0003_0B0B_0003);

      // partial strobe
      wbuf_d[0] = '1; wbuf_s[0] = 8'hFF;
      do_write(4'h1, 32'h8, 0, 3, 0, 0);
      wbuf_d[0] = '0; wbuf_s[0] = 8'h0F;
      do_write(4'h1, 32'h8, 0, 3, 0, 0);
      do_read(4'h2, 32'h8, 0, 3, 0);
      chk("t3_rdata", last_rdata, 64'hFFFF_FFFF_0000_0000);
      chk("proto_clean", proto_err, 0);

      // randomized write / read-back bursts, some crossing the array end
      for (int t = 0; t < 30; t++) begin
         a = $urandom_range(0, MEM_DEPTH*8 + 63);
         l = $urandom_range(0, 15);
         s = $urandom_range(0, 3);
         for (int i = 0; i < 16; i++) begin
            wbuf_d[i] = {$urandom, $urandom};
            wbuf_s[i] = 8'($urandom_range(0, 255));
         end
         do_write(ID_BITS'($urandom), a, l, s, 0, 1);
         do_read(ID_BITS'($urandom), a, l, s, 0);
      end

      // concurrent write and read in disjoint regions
      for (int i = 0; i < 8; i++) begin wbuf_d[i] = {$urandom, $urandom}; wbuf_s[i] = 8'hFF; end
      wbuf_d[0] = '1;
      do_write(4'h0, 32'h100, 3, 3, 0, 0);
      fork
         do_write(4'hA, 32'h800, 7, 3, 0, 1);
         do_read(4'hB, 32'h100, 3, 3, 0);
      join
      do_read(4'hC, 32'h800, 7, 3, 0);

      // out-of-range write: wraps to word 0 or is dropped with SLVERR
      wbuf_d[0] = 64'hA5A5_A5A5_A5A5_A5A5; wbuf_s[0] = 8'hFF;
      do_write(4'h6, BASE_ADDR, 0, 3, 0, 0);
      wbuf_d[0] = 64'hDEAD_BEEF_0BAD_F00D;
      do_write(4'h6, BASE_ADDR + 32'(MEM_DEPTH*8), 0, 3, 0, 0);
      chk("range_bresp", last_bresp, RANGE_EN ? 2'b10 : 2'b00);
      do_read(4'h7, BASE_ADDR, 0, 3, 0);
      chk("range_word0", last_rdata, RANGE_EN ? 64'hA5A5_A5A5_A5A5_A5A5 : 64'hDEAD_BEEF_0BAD_F00D);
      chk("proto_before_drop", proto_err, 0);

      // AWVALID withdrawn before AWREADY
      AWVALID0 = 1; AWADDR0 = 32'h0;
      @(posedge clk); #1 AWVALID0 = 0;
      repeat (2) begin @(posedge clk); #1; end
      chk("proto_aw_drop", proto_err, 1);
      chk("aw_drop_no_b", BVALID0, 0);

      // reset in the middle of a read burst
      start_read(4'hD, 32'h100, 15, 3);
      RREADY0 = 0;
      repeat (3) begin @(posedge clk); #1; end
      chk("pre_rst_rvalid", RVALID0, 1);
      @(negedge clk); #2 reset = 0;
      #1;
      chk("async_rst_rvalid", RVALID0, 0);
      chk("async_rst_proto", proto_err, 0);
      rq.delete();
      @(posedge clk); #1 reset = 1;
      @(posedge clk); #1;
      do_read(4'hE, 32'h100, 3, 3, 0);

      // WLAST asserted on beat 0 of a 2-beat burst
      wbuf_d[0] = 64'h0101_0101_0101_0101; wbuf_d[1] = 64'h0202_0202_0202_0202;
      wbuf_s[0] = 8'hFF; wbuf_s[1] = 8'hFF;
      do_write(4'h8, 32'h300, 1, 3, 1, 0);
      chk("proto_wlast", proto_err, 1);
      do_read(4'h8, 32'h300, 1, 3, 0);
      chk("wlast_beat1_data", last_rdata, 64'h0202_0202_0202_0202);

      repeat (10) @(posedge clk);
      chk("queues_empty", 64'(bq.size() + rq.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
